// File: rtl/seed_key_mix_serial.sv
// -----------------------------------------------------------------------------
// seed_key_mix_serial
//   Byte-serial key-mixing front end of the SEED F-function. It collects the
//   64-bit right half (C word then D word) together with the round key
//   (K0 then K1), one byte per accepted beat, LSB first. It then emits
//   C' = C ^ K0 and D' = (D ^ K1) ^ C' as aligned byte pairs, LSB first, in a
//   fixed 4-cycle burst for the G/adder stage.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous active-high reset (dominates clear)
//   clear      synchronous abort; drops any partial word or burst
//   in_valid   in_data/in_key carry a beat this cycle
//   in_ready   block can accept a beat this cycle (low during the burst)
//   in_data    right-half byte: beats 0-3 = C LSB..MSB, beats 4-7 = D LSB..MSB
//   in_key     round-key byte paired with in_data (K0 then K1)
//   out_valid  out_c/out_d valid; high for exactly 4 cycles per round
//   out_first  marks byte 0 of a burst
//   out_last   marks byte 3 of a burst
//   out_c      C' byte (0 when out_valid is low)
//   out_d      D' byte (0 when out_valid is low)
//   busy       high from the first accepted beat until out_last is presented
// -----------------------------------------------------------------------------
module seed_key_mix_serial #(
  parameter int DATA_W     = 8,
  parameter int WORD_BYTES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] in_key,
  output logic              out_valid,
  output logic              out_first,
  output logic              out_last,
  output logic [DATA_W-1:0] out_c,
  output logic [DATA_W-1:0] out_d,
  output logic              busy
);

  localparam int              IDX_W    = $clog2(WORD_BYTES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_BYTES - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  localparam logic [1:0] LOAD_C = 2'd0;
  localparam logic [1:0] LOAD_D = 2'd1;
  localparam logic [1:0] EMIT   = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] c_buf_q [WORD_BYTES];
  logic [DATA_W-1:0] d_buf_q [WORD_BYTES];
  logic              accept;

  function automatic logic [DATA_W-1:0] key_mix(input logic [DATA_W-1:0] data,
                                                input logic [DATA_W-1:0] key);
    return data ^ key;
  endfunction

  // D' lane folds in the already-mixed C' byte of the same position.
  function automatic logic [DATA_W-1:0] chain_mix(input logic [DATA_W-1:0] data,
                                                  input logic [DATA_W-1:0] key,
                                                  input logic [DATA_W-1:0] c_mixed);
    return data ^ key ^ c_mixed;
  endfunction

  assign in_ready = (state_q != EMIT);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      LOAD_C: begin
        if (accept) begin
          if (idx_q == IDX_LAST) begin
            state_d = LOAD_D;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end
      end
      LOAD_D: begin
        if (accept) begin
          if (idx_q == IDX_LAST) begin
            state_d = EMIT;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end
      end
      EMIT: begin
        // No backpressure: one byte pair leaves every cycle.
        if (idx_q == IDX_LAST) begin
          state_d = LOAD_C;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_ONE;
        end
      end
      default: begin
        state_d = LOAD_C;
        idx_d   = '0;
      end
    endcase
  end

  // Control registers; clear discards any beat presented in the same cycle.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_q <= LOAD_C;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Byte buffers are zeroed on reset/clear so no stale key material survives an abort.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        c_buf_q[i] <= '0;
        d_buf_q[i] <= '0;
      end
    end else if (accept) begin
      if (state_q == LOAD_C) begin
        c_buf_q[idx_q] <= key_mix(in_data, in_key);
      end else if (state_q == LOAD_D) begin
        d_buf_q[idx_q] <= chain_mix(in_data, in_key, c_buf_q[idx_q]);
      end
    end
  end

  assign out_valid = (state_q == EMIT);
  assign out_first = out_valid && (idx_q == '0);
  assign out_last  = out_valid && (idx_q == IDX_LAST);
  assign out_c     = out_valid ? c_buf_q[idx_q] : '0;
  assign out_d     = out_valid ? d_buf_q[idx_q] : '0;
  // Idle means LOAD_C with nothing collected yet.
  assign busy      = (state_q != LOAD_C) || (idx_q != '0);

endmodule

// File: tb/tb_seed_key_mix_serial.sv
module tb_seed_key_mix_serial;

  logic       clk = 1'b0;
  logic       reset, clear, in_valid;
  logic       in_ready, out_valid, out_first, out_last, busy;
  logic [7:0] in_data, in_key, out_c, out_d;

  int n_cmp = 0;
  int n_bad = 0;

  seed_key_mix_serial #(.DATA_W(8), .WORD_BYTES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_first (out_first),
    .out_last  (out_last),
    .out_c     (out_c),
    .out_d     (out_d),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference model: word-level SEED key mixing.
  function automatic logic [31:0] model_cp(input logic [31:0] c, input logic [31:0] k0);
    return c ^ k0;
  endfunction

  function automatic logic [31:0] model_dp(input logic [31:0] c, input logic [31:0] d,
                                           input logic [31:0] k0, input logic [31:0] k1);
    return (d ^ k1) ^ (c ^ k0);
  endfunction

  // Sends one 8-beat word and checks the resulting burst.
  // mode 0: no gaps, 1: 2 idle cycles after beats 2 and 6, 2: random gaps.
  // clr_at >= 0 asserts clear during that burst byte and stops the burst check.
  task automatic send_word(input logic [31:0] c, input logic [31:0] d,
                           input logic [31:0] k0, input logic [31:0] k1,
                           input logic [31:0] exp_c, input logic [31:0] exp_d,
                           input int mode, input int clr_at, input string tag);
    logic [63:0] dat;
    logic [63:0] key;
    int beat;
    int gap;
    dat  = {d, c};
    key  = {k1, k0};
    beat = 0;
    gap  = 0;
    while (beat < 8) begin
      @(negedge clk);
      n_cmp++;
      if ({out_valid, in_ready, busy} !== {1'b0, 1'b1, (beat != 0)}) begin
        n_bad++;
        $display("FAIL %s_load beat%0d: v/rdy/busy got %b want %b", tag, beat,
                 {out_valid, in_ready, busy}, {1'b0, 1'b1, (beat != 0)});
      end
      if (gap > 0 || (mode == 2 && $urandom_range(0, 3) == 0)) begin
        if (gap > 0) gap--;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        in_key   = 8'($urandom);
      end else begin
        in_valid = 1'b1;
        in_data  = dat[8*beat +: 8];
        in_key   = key[8*beat +: 8];
        beat++;
        if (mode == 1 && (beat == 2 || beat == 6)) gap = 2;
      end
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({out_valid, out_first, out_last, in_ready, busy} !==
          {1'b1, (i == 0), (i == 3), 1'b0, 1'b1}) begin
        n_bad++;
        $display("FAIL %s_burst_ctl byte%0d: v/f/l/rdy/busy got %b want %b", tag, i,
                 {out_valid, out_first, out_last, in_ready, busy},
                 {1'b1, (i == 0), (i == 3), 1'b0, 1'b1});
      end
      n_cmp++;
      if ({out_c, out_d} !== {exp_c[8*i +: 8], exp_d[8*i +: 8]}) begin
        n_bad++;
        $display("FAIL %s_burst_data byte%0d: c/d got %h/%h want %h/%h", tag, i,
                 out_c, out_d, exp_c[8*i +: 8], exp_d[8*i +: 8]);
      end
      // Beats offered during the burst must be ignored.
      in_valid = (i == 3) ? 1'b0 : 1'($urandom_range(0, 1));
      in_data  = 8'($urandom);
      in_key   = 8'($urandom);
      if (i == clr_at) begin
        clear    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        clear = 1'b0;
        n_cmp++;
        if ({out_valid, out_first, out_last, in_ready, busy, out_c, out_d} !==
            {5'b00010, 16'h0000}) begin
          n_bad++;
          $display("FAIL %s_after_clear: v/f/l/rdy/busy/c/d got %b/%h/%h want 00010/00/00",
                   tag, {out_valid, out_first, out_last, in_ready, busy}, out_c, out_d);
        end
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset    = 1'b1;
    clear    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    in_key   = 8'h00;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({out_valid, out_first, out_last, in_ready, busy, out_c, out_d} !==
        {5'b00010, 16'h0000}) begin
      n_bad++;
      $display("FAIL reset_state: v/f/l/rdy/busy/c/d got %b/%h/%h want 00010/00/00",
               {out_valid, out_first, out_last, in_ready, busy}, out_c, out_d);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic;
    send_word(32'h44332211, 32'h88776655, 32'h04030201, 32'h08070605,
              32'h40302010, 32'hC0404040, 0, -1, "basic");
  endtask

  task automatic test_bubbles;
    send_word(32'h44332211, 32'h88776655, 32'h04030201, 32'h08070605,
              32'h40302010, 32'hC0404040, 1, -1, "bubbles");
  endtask

  task automatic test_back_to_back;
    logic [7:0]  dq [16];
    logic [7:0]  kq [16];
    logic [31:0] ec [2];
    logic [31:0] ed [2];
    logic [31:0] c, d, k0, k1;
    int ptr, low, burst, bi, nf;
    int fc [2];
    ptr = 0; low = 0; burst = 0; bi = 0; nf = 0;
    fc[0] = -1; fc[1] = -1;
    for (int w = 0; w < 2; w++) begin
      c = $urandom; d = $urandom; k0 = $urandom; k1 = $urandom;
      ec[w] = model_cp(c, k0);
      ed[w] = model_dp(c, d, k0, k1);
      for (int b = 0; b < 4; b++) begin
        dq[8*w + b]     = c[8*b +: 8];
        kq[8*w + b]     = k0[8*b +: 8];
        dq[8*w + 4 + b] = d[8*b +: 8];
        kq[8*w + 4 + b] = k1[8*b +: 8];
      end
    end
    for (int cyc = 0; cyc < 28; cyc++) begin
      @(negedge clk);
      if (!in_ready) low++;
      if (out_valid) begin
        if (out_first && nf < 2) begin
          fc[nf] = cyc;
          nf++;
        end
        n_cmp++;
        if (burst >= 2) begin
          n_bad++;
          $display("FAIL b2b_extra_output: cycle %0d got valid want idle", cyc);
        end else if ({out_c, out_d} !== {ec[burst][8*bi +: 8], ed[burst][8*bi +: 8]}) begin
          n_bad++;
          $display("FAIL b2b_data w%0d byte%0d: got %h/%h want %h/%h", burst, bi,
                   out_c, out_d, ec[burst][8*bi +: 8], ed[burst][8*bi +: 8]);
        end
        bi++;
        if (bi == 4) begin
          bi = 0;
          burst++;
        end
      end
      if (ptr < 16) begin
        in_valid = 1'b1;
        in_data  = dq[ptr];
        in_key   = kq[ptr];
        if (in_ready) ptr++;
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    n_cmp++;
    if (low !== 8) begin
      n_bad++;
      $display("FAIL b2b_ready_low: got %0d cycles want 8", low);
    end
    n_cmp++;
    if (nf !== 2 || (fc[1] - fc[0]) !== 12 || fc[0] !== 8) begin
      n_bad++;
      $display("FAIL b2b_spacing: got firsts=%0d at %0d,%0d want 2 at 8,20", nf, fc[0], fc[1]);
    end
  endtask

  task automatic test_reset_mid_load;
    logic [31:0] c;
    c = 32'hDEADBEEF;
    for (int b = 0; b < 5; b++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = (b < 4) ? c[8*b +: 8] : 8'h5A;
      in_key   = 8'h3C;
    end
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h77;
    in_key   = 8'h11;
    @(negedge clk);
    n_cmp++;
    if ({out_valid, out_first, out_last, in_ready, busy, out_c, out_d} !==
        {5'b00010, 16'h0000}) begin
      n_bad++;
      $display("FAIL rst_mid_load: v/f/l/rdy/busy/c/d got %b/%h/%h want 00010/00/00",
               {out_valid, out_first, out_last, in_ready, busy}, out_c, out_d);
    end
    reset    = 1'b0;
    in_valid = 1'b0;
    send_word(32'h0BADF00D, 32'h12345678, 32'hCAFEBABE, 32'h87654321,
              model_cp(32'h0BADF00D, 32'hCAFEBABE),
              model_dp(32'h0BADF00D, 32'h12345678, 32'hCAFEBABE, 32'h87654321),
              0, -1, "after_rst");
  endtask

  task automatic test_clear;
    logic [31:0] c, d, k0, k1;
    // Clear on the second burst cycle.
    c = $urandom; d = $urandom; k0 = $urandom; k1 = $urandom;
    send_word(c, d, k0, k1, model_cp(c, k0), model_dp(c, d, k0, k1), 0, 1, "clr_burst");
    c = $urandom; d = $urandom; k0 = $urandom; k1 = $urandom;
    send_word(c, d, k0, k1, model_cp(c, k0), model_dp(c, d, k0, k1), 0, -1, "post_clr");
    // Clear together with an offered beat: the beat must be discarded.
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      in_key   = 8'($urandom);
      clear    = (b == 2);
    end
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    n_cmp++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      n_bad++;
      $display("FAIL clr_with_beat: v/rdy/busy got %b want 010", {out_valid, in_ready, busy});
    end
    c = $urandom; d = $urandom; k0 = $urandom; k1 = $urandom;
    send_word(c, d, k0, k1, model_cp(c, k0), model_dp(c, d, k0, k1), 0, -1, "post_clr2");
  endtask

  task automatic test_key_zero;
    send_word(32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0, 32'h0,
              32'hA5A5A5A5, 32'h00000000, 0, -1, "key_zero");
  endtask

  task automatic test_random;
    logic [31:0] c, d, k0, k1;
    for (int r = 0; r < 8; r++) begin
      c = $urandom; d = $urandom; k0 = $urandom; k1 = $urandom;
      send_word(c, d, k0, k1, model_cp(c, k0), model_dp(c, d, k0, k1), 2, -1, "random");
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_bubbles;
    test_back_to_back;
    test_reset_mid_load;
    test_clear;
    test_key_zero;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
